// File: rtl/cell_test_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : cell_test_sequencer
//  Purpose  : Self-checking stimulus generator for a single sys_array_cell.
//             Loads a parameter, applies an input/propagate pair, waits the
//             cell latency and compares cell_out with prop + inp*par.
//  Options  : CELL_TEST_LFSR_EN - draw vectors from a 16-bit Fibonacci LFSR
//             instead of the deterministic counter pattern.
//  Revision : 1.0 - initial release
// ============================================================================
module cell_test_sequencer #(
    parameter int DATA_WIDTH   = 8,
    parameter int NUM_VECTORS  = 8,
    parameter int CELL_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [2*DATA_WIDTH-1:0] cell_out,
    output logic                    param_load,
    output logic [DATA_WIDTH-1:0]   par,
    output logic [DATA_WIDTH-1:0]   inp,
    output logic [2*DATA_WIDTH-1:0] prop,
    output logic                    busy,
    output logic                    done,
    output logic                    mismatch,
    output logic [7:0]              err_count,
    output logic [7:0]              vec_idx,
    output logic [2:0]              code
);

    localparam int                 c_DW2       = 2 * DATA_WIDTH;
    localparam int                 c_CNT_W     = (CELL_LATENCY > 1) ? $clog2(CELL_LATENCY) : 1;
    localparam logic [c_CNT_W-1:0] c_WAIT_LAST = c_CNT_W'(CELL_LATENCY - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [7:0]         c_LAST_VEC  = 8'(NUM_VECTORS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_APPLY = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;

    logic                   r_start_q;
    logic [DATA_WIDTH-1:0]  r_par;
    logic [c_DW2-1:0]       r_exp;
    logic [c_CNT_W-1:0]     r_wait_cnt;
    logic [7:0]             r_err_count;
    logic [7:0]             r_vec_idx;
    logic                   r_done;
    logic                   r_mismatch;

    logic                   w_start_edge;
    logic                   w_run_start;
    logic                   w_wait_last;
    logic [DATA_WIDTH-1:0]  w_p;
    logic [DATA_WIDTH-1:0]  w_i;
    logic [c_DW2-1:0]       w_r;
    logic [c_DW2-1:0]       w_exp;

    // Edge = current sample high while the registered previous sample is low
    assign w_start_edge = start & ~r_start_q;
    assign w_run_start  = w_start_edge & ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_wait_last  = (r_wait_cnt == c_WAIT_LAST);

`ifdef CELL_TEST_LFSR_EN
    logic [15:0] r_lfsr;
    logic [15:0] r_lfsr_vec;
    logic [15:0] w_lfsr_next;
    logic [15:0] w_lfsr_rot;

    // Right-shifting Fibonacci form of taps 16,14,13,11
    assign w_lfsr_next = {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
    assign w_lfsr_rot  = {r_lfsr_vec[3:0], r_lfsr_vec[15:4]};

    // P comes from the live LFSR in LOAD; I and R come from the copy captured
    // on that LOAD edge so all three operands belong to the same LFSR value.
    assign w_p = r_lfsr[DATA_WIDTH-1:0];
    assign w_i = r_lfsr_vec[2*DATA_WIDTH-1:DATA_WIDTH];
    assign w_r = w_lfsr_rot[c_DW2-1:0];

    // LFSR: reseed on reset and run start, step once per vector on the LOAD edge
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_lfsr     <= 16'hACE1;
            r_lfsr_vec <= 16'h0000;
        end else if (w_run_start) begin
            r_lfsr     <= 16'hACE1;
        end else if (r_state == S_LOAD) begin
            r_lfsr     <= w_lfsr_next;
            r_lfsr_vec <= r_lfsr;
        end
    end
`else
    // Counter pattern for vector k: P = k+1, I = 2k+3, R = k << DATA_WIDTH
    assign w_p = DATA_WIDTH'(r_vec_idx + 8'd1);
    assign w_i = DATA_WIDTH'({r_vec_idx, 1'b0} + 9'd3);
    assign w_r = c_DW2'({8'd0, r_vec_idx} << DATA_WIDTH);
`endif

    // Expected cell output, computed at full operand width and wrapped
    assign w_exp = w_r + ({{DATA_WIDTH{1'b0}}, w_i} * {{DATA_WIDTH{1'b0}}, r_par});

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and per-state cell drive
    always_comb begin
        w_state_next = r_state;
        param_load   = 1'b0;
        inp          = '0;
        prop         = '0;
        busy         = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_start_edge) begin
                    w_state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                param_load   = 1'b1;
                busy         = 1'b1;
                w_state_next = S_APPLY;
            end
            S_APPLY: begin
                inp          = w_i;
                prop         = w_r;
                busy         = 1'b1;
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                busy = 1'b1;
                if (w_wait_last) begin
                    w_state_next = (r_vec_idx == c_LAST_VEC) ? S_DONE : S_LOAD;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Run bookkeeping: start history, held parameter, expected value, compare, counters
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_start_q   <= 1'b0;
            r_par       <= '0;
            r_exp       <= '0;
            r_wait_cnt  <= '0;
            r_err_count <= 8'd0;
            r_vec_idx   <= 8'd0;
            r_done      <= 1'b0;
            r_mismatch  <= 1'b0;
        end else begin
            r_start_q  <= start;
            r_mismatch <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_start_edge) begin
                        r_err_count <= 8'd0;
                        r_vec_idx   <= 8'd0;
                        r_done      <= 1'b0;
                    end
                end
                S_LOAD: begin
                    r_par <= w_p;
                end
                S_APPLY: begin
                    r_exp      <= w_exp;
                    r_wait_cnt <= '0;
                end
                S_WAIT: begin
                    if (w_wait_last) begin
                        if (cell_out != r_exp) begin
                            r_mismatch <= 1'b1;
                            if (r_err_count != 8'hFF) begin
                                r_err_count <= r_err_count + 8'd1;
                            end
                        end
                        if (r_vec_idx == c_LAST_VEC) begin
                            r_done <= 1'b1;
                        end else begin
                            r_vec_idx <= r_vec_idx + 8'd1;
                        end
                    end else begin
                        r_wait_cnt <= r_wait_cnt + c_CNT_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    // par shows the new value during LOAD and holds it until the next LOAD
    assign par       = (r_state == S_LOAD) ? w_p : r_par;
    assign done      = r_done;
    assign mismatch  = r_mismatch;
    assign err_count = r_err_count;
    assign vec_idx   = r_vec_idx;
    assign code      = {r_done, busy, (r_err_count != 8'd0)};

endmodule
`default_nettype wire

// File: tb/tb_cell_test_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cell_test_sequencer
//  Purpose  : Scoreboard bench for cell_test_sequencer with an ideal
//             registered cell model (optionally faulted on vector 2) and a
//             second latency-3 instance driven by a stuck-at-zero cell.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cell_test_sequencer;

    localparam int NV = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        start3;
    logic        force_vec2 = 1'b0;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    logic [15:0] cell_out;
    logic        param_load, busy, done, mismatch;
    logic [7:0]  par, inp, err_count, vec_idx;
    logic [15:0] prop;
    logic [2:0]  code;

    logic [15:0] cell_out3;
    logic        param_load3, busy3, done3, mismatch3;
    logic [7:0]  par3, inp3, err_count3, vec_idx3;
    logic [15:0] prop3;
    logic [2:0]  code3;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cell_test_sequencer dut (
        .clk(clk), .reset_n(reset_n), .start(start), .cell_out(cell_out),
        .param_load(param_load), .par(par), .inp(inp), .prop(prop),
        .busy(busy), .done(done), .mismatch(mismatch), .err_count(err_count),
        .vec_idx(vec_idx), .code(code)
    );

    cell_test_sequencer #(.CELL_LATENCY(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .start(start3), .cell_out(cell_out3),
        .param_load(param_load3), .par(par3), .inp(inp3), .prop(prop3),
        .busy(busy3), .done(done3), .mismatch(mismatch3), .err_count(err_count3),
        .vec_idx(vec_idx3), .code(code3)
    );

    // Ideal cell: registered prop + inp*param, optionally zeroed on vector 2
    logic [7:0]  cell_par = 8'd0;
    logic [15:0] cell_q   = 16'd0;
    always @(posedge clk) begin
        if (param_load) cell_par <= par;
        cell_q <= (force_vec2 && vec_idx == 8'd2) ? 16'h0000 : prop + inp * cell_par;
    end
    assign cell_out  = cell_q;
    assign cell_out3 = 16'h0000;

    typedef struct {
        logic [7:0]  idx;
        logic [7:0]  par;
        logic [7:0]  inp;
        logic [15:0] prop;
    } vec_t;

    typedef struct {
        int         done_cyc;
        logic [7:0] err;
        logic [2:0] code;
        int         mism;
    } run_t;

    vec_t q_vec[$];
    run_t q_run[$];
    run_t q_run3[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor for the latency-1 instance
    vec_t cur;
    logic apply_pend = 1'b0;
    logic done_d     = 1'b0;
    int   mism_cnt   = 0;
    always @(negedge clk) begin
        if (!reset_n) begin
            apply_pend = 1'b0;
            done_d     = 1'b0;
            mism_cnt   = 0;
        end else begin
            if (apply_pend) begin
                chk("apply_inp", inp, cur.inp);
                chk("apply_prop", prop, cur.prop);
                apply_pend = 1'b0;
            end
            if (param_load) begin
                chk("load_expected", q_vec.size() != 0, 1);
                if (q_vec.size() != 0) begin
                    cur = q_vec.pop_front();
                    chk("load_vec_idx", vec_idx, cur.idx);
                    chk("load_par", par, cur.par);
                    apply_pend = 1'b1;
                end
            end
            if (mismatch) mism_cnt++;
            if (done && !done_d) begin
                chk("run_expected", q_run.size() != 0, 1);
                if (q_run.size() != 0) begin
                    run_t r;
                    r = q_run.pop_front();
                    chk("done_cycle", cyc, r.done_cyc);
                    chk("run_err_count", err_count, r.err);
                    chk("run_code", code, r.code);
                    chk("run_mismatch_pulses", mism_cnt, r.mism);
                    chk("run_last_vec_idx", vec_idx, NV - 1);
                end
                mism_cnt = 0;
            end
            done_d = done;
        end
    end

    // Monitor for the latency-3 instance
    logic done3_d   = 1'b0;
    int   mism3_cnt = 0;
    always @(negedge clk) begin
        if (!reset_n) begin
            done3_d   = 1'b0;
            mism3_cnt = 0;
        end else begin
            if (mismatch3) mism3_cnt++;
            if (done3 && !done3_d) begin
                chk("run3_expected", q_run3.size() != 0, 1);
                if (q_run3.size() != 0) begin
                    run_t r;
                    r = q_run3.pop_front();
                    chk("run3_done_cycle", cyc, r.done_cyc);
                    chk("run3_err_count", err_count3, r.err);
                    chk("run3_code", code3, r.code);
                    chk("run3_mismatch_pulses", mism3_cnt, r.mism);
                end
                mism3_cnt = 0;
            end
            done3_d = done3;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_vectors();
`ifdef CELL_TEST_LFSR_EN
        logic [15:0] l;
        l = 16'hACE1;
`endif
        for (int k = 0; k < NV; k++) begin
            vec_t v;
            v.idx = 8'(k);
`ifdef CELL_TEST_LFSR_EN
            v.par  = l[7:0];
            v.inp  = l[15:8];
            v.prop = {l[3:0], l[15:4]};
            l      = {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
`else
            v.par  = 8'(k + 1);
            v.inp  = 8'(2 * k + 3);
            v.prop = 16'(k << 8);
`endif
            q_vec.push_back(v);
        end
    endtask

    // Raise start; the edge is taken on the next clock, run ends NV*3 cycles later
    task automatic start_run(input logic [7:0] exp_err);
        run_t r;
        push_vectors();
        r.done_cyc = cyc + 1 + NV * 3;
        r.err      = exp_err;
        r.code     = {1'b1, 1'b0, exp_err != 8'd0};
        r.mism     = int'(exp_err);
        q_run.push_back(r);
        start = 1'b1;
    endtask

    task automatic wait_done(input int max_cyc);
        int n;
        n = 0;
        while (done !== 1'b1 && n < max_cyc) begin
            tick();
            n++;
        end
        if (done !== 1'b1) begin
            n_checks++;
            n_errors++;
            $display("FAIL done_timeout: done=%b after %0d cycles, required 1", done, n);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_param_load"}, param_load, 0);
        chk({tag, "_par"}, par, 0);
        chk({tag, "_inp"}, inp, 0);
        chk({tag, "_prop"}, prop, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_mismatch"}, mismatch, 0);
        chk({tag, "_err_count"}, err_count, 0);
        chk({tag, "_vec_idx"}, vec_idx, 0);
        chk({tag, "_code"}, code, 0);
        chk({tag, "_dut3_outs"}, {param_load3, par3, inp3, prop3, busy3, done3, mismatch3}, 0);
        chk({tag, "_dut3_cnt"}, {err_count3, vec_idx3, code3}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        run_t r3;
        reset_n = 1'b0;
        start   = 1'b0;
        start3  = 1'b0;
        tick();
        tick();
        chk_reset_outputs("reset");
        reset_n = 1'b1;
        tick();

        // Ideal cell
        start_run(8'd0);
        tick();
        start = 1'b0;
        wait_done(60);
        tick();
        tick();

        // Cell faulted on vector 2 only
        force_vec2 = 1'b1;
        start_run(8'd1);
        tick();
        start = 1'b0;
        wait_done(60);
        tick();

        // Start toggled mid-run, then held high across DONE
        start_run(8'd1);
        tick();
        for (int i = 0; i < 8; i++) begin
            start = ~start;
            tick();
        end
        start = 1'b1;
        wait_done(60);
        repeat (10) tick();
        chk("held_start_done", done, 1);
        chk("held_start_busy", busy, 0);
        chk("held_start_err", err_count, 1);
        start      = 1'b0;
        force_vec2 = 1'b0;
        tick();
        tick();

        // Fresh press after release clears err_count
        start_run(8'd0);
        tick();
        start = 1'b0;
        chk("restart_err_cleared", err_count, 0);
        chk("restart_done_cleared", done, 0);
        wait_done(60);
        tick();

        // Reset during vector 4 abandons the run
        start_run(8'd0);
        tick();
        start = 1'b0;
        n = 0;
        while (vec_idx !== 8'd4 && n < 100) begin
            tick();
            n++;
        end
        chk("reach_vec4", vec_idx, 4);
        reset_n = 1'b0;
        tick();
        chk_reset_outputs("midrun_reset");
        q_vec.delete();
        q_run.delete();
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        chk("post_reset_idle_busy", busy, 0);
        chk("post_reset_idle_done", done, 0);
        start_run(8'd0);
        tick();
        start = 1'b0;
        wait_done(60);
        tick();

        // Latency-3 instance against a stuck-at-zero cell
        r3.done_cyc = cyc + 1 + NV * 5;
        r3.err      = 8'd8;
        r3.code     = 3'b101;
        r3.mism     = 8;
        q_run3.push_back(r3);
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        n = 0;
        while (done3 !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk("run3_done_seen", done3, 1);
        tick();
        tick();

        chk("run_queues_empty", q_run.size() + q_run3.size(), 0);
        chk("vec_queue_empty", q_vec.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
